// File: rtl/block_buffer_if.sv
// Bus bundle between the address generator / DES core side and block_buffer.
// The master modport is the environment; the slave modport is the buffer itself.
interface block_buffer_if;
    logic [15:0] address;
    logic        write_en;
    logic        read_en;
    logic [7:0]  wdata;
    logic [63:0] block_out;
    logic        block_valid;
    logic        block_ready;
    logic        result_load;
    logic [63:0] result_in;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        result_pending;
    logic        err;
    logic        err_clr;

    modport master (
        output address, write_en, read_en, wdata, block_ready,
               result_load, result_in, err_clr,
        input  block_out, block_valid, rdata, rdata_valid,
               result_pending, err
    );

    modport slave (
        input  address, write_en, read_en, wdata, block_ready,
               result_load, result_in, err_clr,
        output block_out, block_valid, rdata, rdata_valid,
               result_pending, err
    );
endinterface

// File: rtl/block_buffer.sv
// Byte-wide staging buffer around a 64-bit DES core: assembles 8 written bytes
// into a block, hands it off, then lets the 8 result bytes be read back.
module block_buffer (
    input  logic           clk,
    input  logic           n_rst,
    block_buffer_if.slave  io_bus
);

    typedef enum logic [1:0] {FILL, FULL, BUSY, DRAIN} state_t;

    state_t      r_state;
    logic [2:0]  r_wrCount;
    logic [2:0]  r_rdCount;
    logic [63:0] r_block;
    logic [63:0] r_result;
    logic [7:0]  r_rdata;
    logic        r_rdataValid;
    logic        r_blockValid;
    logic        r_resultPending;
    logic        r_err;

    logic [2:0]  w_lane;
    logic [5:0]  w_laneBase;
    logic        w_wrErr;
    logic        w_rdErr;
    logic        w_ldErr;
    logic        w_anyErr;

    // Lane 0 is the most significant byte, so the bit offset is (7 - lane) * 8.
    assign w_lane     = io_bus.address[2:0];
    assign w_laneBase = {~w_lane, 3'b000};

    assign w_wrErr  = io_bus.write_en    && (r_state != FILL);
    assign w_rdErr  = io_bus.read_en     && (r_state != DRAIN);
    assign w_ldErr  = io_bus.result_load && (r_state != BUSY);
    assign w_anyErr = w_wrErr || w_rdErr || w_ldErr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= FILL;
            r_wrCount       <= 3'd0;
            r_rdCount       <= 3'd0;
            r_block         <= 64'd0;
            r_result        <= 64'd0;
            r_rdata         <= 8'h00;
            r_rdataValid    <= 1'b0;
            r_blockValid    <= 1'b0;
            r_resultPending <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_rdataValid <= 1'b0;

            // A fresh error wins over a simultaneous clear.
            if (w_anyErr) begin
                r_err <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                FILL: begin
                    if (io_bus.write_en) begin
                        r_block[w_laneBase +: 8] <= io_bus.wdata;
                        if (r_wrCount == 3'd7) begin
                            r_state      <= FULL;
                            r_wrCount    <= 3'd0;
                            r_blockValid <= 1'b1;
                        end else begin
                            r_wrCount <= r_wrCount + 3'd1;
                        end
                    end
                end
                FULL: begin
                    if (io_bus.block_ready) begin
                        r_state      <= BUSY;
                        r_blockValid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (io_bus.result_load) begin
                        r_result        <= io_bus.result_in;
                        r_state         <= DRAIN;
                        r_resultPending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (io_bus.read_en) begin
                        r_rdata      <= r_result[w_laneBase +: 8];
                        r_rdataValid <= 1'b1;
                        // Last byte out: start the next block from a clean slate.
                        if (r_rdCount == 3'd7) begin
                            r_state         <= FILL;
                            r_rdCount       <= 3'd0;
                            r_resultPending <= 1'b0;
                            r_block         <= 64'd0;
                        end else begin
                            r_rdCount <= r_rdCount + 3'd1;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign io_bus.block_out      = r_block;
    assign io_bus.block_valid    = r_blockValid;
    assign io_bus.rdata          = r_rdata;
    assign io_bus.rdata_valid    = r_rdataValid;
    assign io_bus.result_pending = r_resultPending;
    assign io_bus.err            = r_err;

endmodule

// File: doc/block_buffer.md
BLOCK_BUFFER -- requirements
Module: block_buffer

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 address  input  16  byte address from the address generator; only address[2:0] (lane) used, bits [15:3] ignored.
REQ-005 write_en  input  1  store wdata into input block lane address[2:0] this cycle.
REQ-006 read_en  input  1  fetch result byte from lane address[2:0] this cycle.
REQ-007 wdata  input  8  byte to store.
REQ-008 block_out  output  64  assembled plaintext block to DES core; lane 0 = bits [63:56], lane 7 = bits [7:0].
REQ-009 block_valid  output  1  block_out complete and held stable.
REQ-010 block_ready  input  1  DES core accepts block_out.
REQ-011 result_load  input  1  DES core presents result_in this cycle.
REQ-012 result_in  input  64  DES result, same lane mapping as block_out.
REQ-013 rdata  output  8  registered read byte.
REQ-014 rdata_valid  output  1  rdata valid, one-cycle pulse.
REQ-015 result_pending  output  1  result held, not yet fully drained.
REQ-016 err  output  1  sticky protocol-error flag.
REQ-017 err_clr  input  1  synchronous clear of err.

Function
REQ-018 FSM states SHALL be FILL, FULL, BUSY, DRAIN; all outputs registered.
REQ-019 FILL: write_en stores wdata into lane address[2:0] and increments 3-bit write count; repeated lanes overwrite.
REQ-020 FILL: when the 8th write is accepted (count 7 plus write_en), next state FULL, count to 0, block_valid 1 on the following cycle.
REQ-021 FULL: block_valid held 1, block_out stable; block_ready 1 -> BUSY, block_valid 0 next cycle.
REQ-022 BUSY: result_load 1 -> capture result_in into result register, next state DRAIN, result_pending 1 next cycle.
REQ-023 result_load outside BUSY SHALL be ignored and set err.
REQ-024 DRAIN: read_en -> rdata = result lane address[2:0], rdata_valid 1 on the next cycle only; read count increments.
REQ-025 DRAIN: 8th read -> next state FILL, result_pending 0 and read count 0 on the same edge rdata_valid rises; input block cleared to 0.
REQ-026 read_en outside DRAIN SHALL leave rdata unchanged, keep rdata_valid 0, and set err.
REQ-027 write_en outside FILL SHALL be dropped (no lane change) and set err.
REQ-028 Simultaneous write_en and read_en SHALL each be handled per their own state rules in the same cycle.
REQ-029 err sets on any error above; err_clr clears it; an error in the same cycle as err_clr leaves err 1.
REQ-030 block_ready outside FULL SHALL have no effect.

Reset
REQ-031 n_rst low SHALL immediately force state FILL, counts 0, block_out 0, result register 0, rdata 0x00, block_valid 0, rdata_valid 0, result_pending 0, err 0.
REQ-032 Reset mid-operation SHALL discard partial blocks and undrained results; first write after release counts as write 1.

Verification
REQ-033 Writes 0x11..0x88 to addresses 0x0000..0x0007 -> block_out 0x1122334455667788, block_valid 1 one cycle after 8th write.
REQ-034 Block valid, block_ready held 0 for 5 cycles then 1 -> block_valid stays 1 and block_out unchanged for 5 cycles, drops 1 cycle after ready.
REQ-035 BUSY, result_load with result_in 0xA1B2C3D4E5F60718; reads at addresses 0x0007 down to 0x0000 -> rdata 0x18,0x07,0xF6,0xE5,0xD4,0xC3,0xB2,0xA1, each one cycle after read_en; result_pending 0 after 8th read.
REQ-036 write_en with wdata 0xFF in FULL -> block_out unchanged, err 1; err_clr pulse -> err 0.
REQ-037 n_rst low after 4 writes, release, 8 writes of 0x01 -> block_valid after exactly 8 writes, block_out 0x0101010101010101.
REQ-038 Address 0xFFF9 write 0x5A in FILL -> lane 1 (bits [55:48]) = 0x5A; read_en in FILL -> rdata_valid stays 0, err 1.
